// File: rtl/mips_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory and buffers
// {pc, inst} pairs in a small FIFO presented to decode over valid/ready.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_q;
  logic [31:0]   tag_q;
  logic          inflight_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  assign mem_write  = 1'b0;
  assign mem_wdata  = 32'h0;
  assign mem_addr   = {2'b00, pc_q[31:2]};

  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  assign pop  = inst_valid & inst_ready;
  assign push = inflight_q;

  // Credit check: buffered plus in-flight entries, minus the slot freed this cycle,
  // must leave room so a response can never find the FIFO full.
  always_comb begin
    occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & ~32'h3;
      tag_q      <= 32'h0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc_q[i]   <= 32'h0;
        fifo_inst_q[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      // Flush buffered entries; the response in flight this cycle is dropped by not pushing.
      pc_q       <= redirect_pc & ~32'h3;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (issue) begin
        tag_q <= pc_q;
        pc_q  <= pc_q + 32'd4;
      end
      inflight_q <= issue;
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= tag_q;
        fifo_inst_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule
